// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the NABU MegaMapper trap sequencer:
// FSM encoding, default NMI pulse width and the trap-acknowledge port offset.
package trap_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_NMI      = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_RELEASE  = 2'd3
    } trap_st_e;

    localparam int unsigned NMI_CYCLES_DEFAULT = 4;
    localparam int unsigned PULSE_CNT_W        = 4;

    // Offset of the trap-acknowledge port inside mapper I/O space; decoded upstream into ack_strobe.
    localparam logic [7:0] TRAP_ACK_PORT_OFS   = 8'h38;

endpackage

// File: rtl/trap_sequencer_edge_detect.sv
// One-flop edge detector for a Z80 bus strobe; the sample resets high (strobe idle).
module trap_sequencer_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_d;
    logic sig_q;

    always_comb begin
        sig_d = sig;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/trap_sequencer.sv
// Virtualization trap sequencer: captures a trapped guest I/O cycle, pulses NMI,
// waits for the monitor's acknowledge and releases on the next opcode fetch.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int unsigned NMI_CYCLES = NMI_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       m1_n,
    input  logic       trap_en,
    input  logic       trap_hit,
    input  logic       ack_strobe,
    output logic       nmi_n,
    output logic       trap_state,
    output logic [7:0] trap_port,
    output logic [7:0] trap_data,
    output logic       trap_dir,
    output logic       overrun
);

    localparam logic [PULSE_CNT_W-1:0] NMI_LOAD = PULSE_CNT_W'(NMI_CYCLES);

    logic iorq_rise, iorq_fall;
    logic m1_rise, m1_fall;
    logic ack_rise, ack_fall;

    trap_sequencer_edge_detect u_iorq_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (iorq_n),
        .rise    (iorq_rise),
        .fall    (iorq_fall)
    );

    trap_sequencer_edge_detect u_m1_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (m1_n),
        .rise    (m1_rise),
        .fall    (m1_fall)
    );

    trap_sequencer_edge_detect u_ack_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (ack_strobe),
        .rise    (ack_rise),
        .fall    (ack_fall)
    );

    // Direction comes from wr_n alone; rd_n is carried for bus completeness.
    logic unused_bits;
    assign unused_bits = iorq_rise | m1_rise | ack_fall | rd_n;

    trap_st_e               state_q, state_d;
    logic [PULSE_CNT_W-1:0] cnt_q, cnt_d;
    logic                   nmi_n_q, nmi_n_d;
    logic                   trap_state_q, trap_state_d;
    logic [7:0]             trap_port_q, trap_port_d;
    logic [7:0]             trap_data_q, trap_data_d;
    logic                   trap_dir_q, trap_dir_d;
    logic                   overrun_q, overrun_d;
    logic                   trap_cyc;

    // Interrupt-acknowledge cycles drive iorq_n with m1_n low and never trap.
    assign trap_cyc = iorq_fall & m1_n & trap_en & trap_hit;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        nmi_n_d      = nmi_n_q;
        trap_state_d = trap_state_q;
        trap_port_d  = trap_port_q;
        trap_data_d  = trap_data_q;
        trap_dir_d   = trap_dir_q;
        overrun_d    = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (trap_cyc) begin
                    state_d      = ST_NMI;
                    cnt_d        = NMI_LOAD;
                    nmi_n_d      = 1'b0;
                    trap_state_d = 1'b1;
                    trap_port_d  = addr;
                    trap_dir_d   = ~wr_n;
                    trap_data_d  = wr_n ? 8'h00 : data_in;
                end
            end
            ST_NMI: begin
                if (cnt_q <= PULSE_CNT_W'(1)) begin
                    state_d = ST_WAIT_ACK;
                    cnt_d   = '0;
                    nmi_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - PULSE_CNT_W'(1);
                end
            end
            ST_WAIT_ACK: begin
                if (ack_rise) begin
                    state_d      = ST_RELEASE;
                    trap_state_d = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (m1_fall) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An ack that finds overrun already set wins over a same-cycle new overrun.
        if (ack_rise && overrun_q) begin
            overrun_d = 1'b0;
        end else if (trap_cyc && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            nmi_n_q      <= 1'b1;
            trap_state_q <= 1'b0;
            trap_port_q  <= 8'h00;
            trap_data_q  <= 8'h00;
            trap_dir_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nmi_n_q      <= nmi_n_d;
            trap_state_q <= trap_state_d;
            trap_port_q  <= trap_port_d;
            trap_data_q  <= trap_data_d;
            trap_dir_q   <= trap_dir_d;
            overrun_q    <= overrun_d;
        end
    end

    // nmi_n comes straight from a flop that resets high, so it cannot glitch low.
    assign nmi_n      = nmi_n_q;
    assign trap_state = trap_state_q;
    assign trap_port  = trap_port_q;
    assign trap_data  = trap_data_q;
    assign trap_dir   = trap_dir_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: behavioural model plus directed and random stimulus.
module tb_trap_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] addr = 8'h00, data_in = 8'h00;
    logic       iorq_n = 1'b0, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1;
    logic       trap_en = 1'b0, trap_hit = 1'b0, ack_strobe = 1'b0;
    logic       nmi_n, trap_state, trap_dir, overrun;
    logic [7:0] trap_port, trap_data;

    trap_sequencer #(.NMI_CYCLES(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .addr       (addr),
        .data_in    (data_in),
        .iorq_n     (iorq_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .m1_n       (m1_n),
        .trap_en    (trap_en),
        .trap_hit   (trap_hit),
        .ack_strobe (ack_strobe),
        .nmi_n      (nmi_n),
        .trap_state (trap_state),
        .trap_port  (trap_port),
        .trap_data  (trap_data),
        .trap_dir   (trap_dir),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a trap is "held" while busy; nmi stays low while pulses remain;
    // after the ack the trap waits for the next opcode fetch.
    bit         m_busy, m_wfetch, m_ov, m_dir;
    int         m_nleft;
    logic [7:0] m_port, m_data;
    bit         p_iorq, p_m1, p_ack;

    task automatic model_reset();
        m_busy = 0; m_wfetch = 0; m_ov = 0; m_dir = 0; m_nleft = 0;
        m_port = 8'h00; m_data = 8'h00;
        p_iorq = 1; p_m1 = 1; p_ack = 1;
    endtask

    task automatic model_step();
        bit start, trapped, ackr, m1f, idle;
        start   = p_iorq && !iorq_n && m1_n;
        trapped = start && trap_en && trap_hit;
        ackr    = !p_ack && ack_strobe;
        m1f     = p_m1 && !m1_n;
        idle    = !m_busy && !m_wfetch;
        if (ackr && m_ov) m_ov = 0;
        else if (trapped && !idle) m_ov = 1;
        if (idle && trapped) begin
            m_busy = 1; m_nleft = N;
            m_port = addr; m_dir = !wr_n; m_data = wr_n ? 8'h00 : data_in;
        end else if (m_busy && m_nleft > 0) begin
            m_nleft = m_nleft - 1;
        end else if (m_busy && ackr) begin
            m_busy = 0; m_wfetch = 1;
        end else if (m_wfetch && m1f) begin
            m_wfetch = 0;
        end
        p_iorq = iorq_n; p_m1 = m1_n; p_ack = ack_strobe;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("model_nmi_n",      nmi_n,      (m_nleft > 0) ? 8'd0 : 8'd1);
            chk("model_trap_state", trap_state, m_busy);
            chk("model_trap_port",  trap_port,  m_port);
            chk("model_trap_data",  trap_data,  m_data);
            chk("model_trap_dir",   trap_dir,   m_dir);
            chk("model_overrun",    overrun,    m_ov);
        end
    end

    task automatic drive_io(input logic [7:0] a, input logic [7:0] d, input logic wr,
                            input logic hit, input logic m1);
        @(negedge clk);
        addr = a; data_in = d; wr_n = !wr; rd_n = wr; trap_hit = hit; m1_n = m1; iorq_n = 1'b0;
    endtask

    task automatic end_io();
        @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1; trap_hit = 1'b0;
    endtask

    task automatic fetch();
        @(negedge clk); m1_n = 1'b0;
        @(negedge clk); m1_n = 1'b1;
    endtask

    // Runs a non-trapping I/O cycle and requires nmi_n/trap_state to stay idle.
    task automatic no_trap(input string name, input logic en, input logic hit, input logic m1);
        int highs;
        trap_en = en;
        drive_io(8'h41, 8'h11, 1'b1, hit, m1);
        highs = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #3;
            if (nmi_n === 1'b1 && trap_state === 1'b0) highs++;
            if (i == 0) end_io();
        end
        chk(name, 8'(highs), 8'd4);
        trap_en = 1'b1;
    endtask

    initial begin
        int lows;
        // Reset with iorq_n held low: nothing may leave reset values.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_nmi_n", nmi_n, 8'd1);
            chk("rst_state", trap_state, 8'd0);
            chk("rst_port", trap_port, 8'h00);
            chk("rst_overrun", overrun, 8'd0);
        end
        iorq_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1; trap_en = 1'b1;

        // OUT (0x41),0xA5
        drive_io(8'h41, 8'hA5, 1'b1, 1'b1, 1'b1);
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #3;
            if (i == 0) begin
                chk("out_port", trap_port, 8'h41);
                chk("out_data", trap_data, 8'hA5);
                chk("out_dir", trap_dir, 8'd1);
                chk("out_state", trap_state, 8'd1);
            end
            if (nmi_n === 1'b0) lows++;
            if (i == 0) end_io();
        end
        chk("nmi_low_cycles", 8'(lows), 8'(N));

        // Second trapped OUT lands together with the first ack edge.
        drive_io(8'h42, 8'h5A, 1'b1, 1'b1, 1'b1);
        ack_strobe = 1'b1;
        @(posedge clk); #3;
        chk("ovr_port_held", trap_port, 8'h41);
        chk("ovr_data_held", trap_data, 8'hA5);
        chk("ovr_set", overrun, 8'd1);
        chk("ack_state_low", trap_state, 8'd0);
        end_io();
        @(negedge clk); ack_strobe = 1'b0;
        @(negedge clk); ack_strobe = 1'b1;
        @(posedge clk); #3;
        chk("ovr_cleared", overrun, 8'd0);
        @(negedge clk); ack_strobe = 1'b0;
        fetch();

        // IN from 0x40 is accepted, proving the fetch returned to idle.
        drive_io(8'h40, 8'hFF, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #3;
        chk("in_port", trap_port, 8'h40);
        chk("in_data", trap_data, 8'h00);
        chk("in_dir", trap_dir, 8'd0);
        chk("in_state", trap_state, 8'd1);
        end_io();
        repeat (6) @(negedge clk);
        ack_strobe = 1'b1;
        @(posedge clk); #3;
        chk("in_ack_state", trap_state, 8'd0);
        @(negedge clk); ack_strobe = 1'b0;
        fetch();

        no_trap("no_trap_en0", 1'b0, 1'b1, 1'b1);
        no_trap("no_trap_hit0", 1'b1, 1'b0, 1'b1);
        no_trap("no_trap_intack", 1'b1, 1'b1, 1'b0);

        // Reset during the NMI pulse.
        drive_io(8'h43, 8'h77, 1'b1, 1'b1, 1'b1);
        end_io();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_nmi_n", nmi_n, 8'd1);
        chk("midrst_state", trap_state, 8'd0);
        chk("midrst_port", trap_port, 8'h00);
        chk("midrst_data", trap_data, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // Random bus activity against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(0, 999) < 3) reset_n = 1'b0;
            if ($urandom_range(0, 99) < 12) begin
                iorq_n = ~iorq_n;
                if (!iorq_n) begin
                    addr = 8'($urandom); data_in = 8'($urandom);
                    wr_n = 1'($urandom); rd_n = ~wr_n;
                end
            end
            if ($urandom_range(0, 99) < 8) m1_n = ~m1_n;
            if ($urandom_range(0, 99) < 6) ack_strobe = ~ack_strobe;
            trap_en  = ($urandom_range(0, 9) != 0);
            trap_hit = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Sequences virtualization traps for the NABU MegaMapper CPLD. When trapping is enabled and the guest issues a trapped I/O cycle, the block latches the port, direction and write data, pulses NMI toward the Z80, holds the trap state until the monitor acknowledges through mapper I/O space, then releases on the next opcode fetch. It sits between the bus decode and mode logic and the CPU interrupt pins, alongside the control register.

## Interface
Parameters:
- NMI_CYCLES, 4: width of the nmi_n low pulse in clk cycles (range 1..15).

Ports:
- clk  in  1  Z80 system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  8  Z80 A[7:0].
- data_in  in  8  Z80 D[7:0], input view.
- iorq_n, rd_n, wr_n, m1_n  in  1 each  Z80 bus strobes, sampled on clk.
- trap_en  in  1  control register bit 0; enables trapping.
- trap_hit  in  1  combinational: current addr is a trapped guest port.
- ack_strobe  in  1  level, high while the monitor writes the trap-acknowledge port.
- nmi_n  out  1  NMI to CPU, active low.
- trap_state  out  1  high from capture until release.
- trap_port  out  8  latched port address.
- trap_data  out  8  latched OUT data; 0x00 for IN.
- trap_dir  out  1  1 = OUT/write, 0 = IN/read.
- overrun  out  1  sticky: a trapped cycle occurred while trap_state was high.

## Operation
- I/O cycle start: iorq_n sampled low, previous sample high, m1_n high. Interrupt-acknowledge cycles (iorq_n and m1_n both low) never trap.
- States: IDLE, NMI, WAIT_ACK, RELEASE.
- IDLE: on cycle start with trap_en && trap_hit, latch trap_port=addr, trap_dir=!wr_n, trap_data=data_in if !wr_n else 0x00; load the pulse counter with NMI_CYCLES; go to NMI. trap_state rises on this same edge.
- NMI: nmi_n low; count down; at count 1 go to WAIT_ACK with nmi_n high from the next cycle.
- WAIT_ACK: nmi_n high and trap_state high. A rising edge of ack_strobe (sampled low then high) goes to RELEASE.
- RELEASE: trap_state drops on entry. The first m1_n falling edge (next opcode fetch) goes to IDLE.
- Trapped cycle start in any non-IDLE state: no recapture, latches unchanged, overrun set. overrun clears only on reset or an ack_strobe rising edge that sees overrun already set. Clear takes precedence over a same-cycle set.
- trap_en deassertion mid-sequence does not abort; it only blocks new entries from IDLE.
- Latched fields hold until the next capture; they are not cleared on release.

## Timing
- Reset values: state IDLE, nmi_n=1, trap_state=0, trap_port=0x00, trap_data=0x00, trap_dir=0, overrun=0, internal edge-detect samples=1.
- Capture latency: outputs are valid on the clk edge that samples the iorq_n falling edge. nmi_n goes low that same edge and stays low exactly NMI_CYCLES cycles.
- Ack edge to trap_state low: 1 cycle.
- Reset mid-sequence: immediate return to reset values. nmi_n must never glitch low during reset.
- Simultaneous ack edge and trapped cycle start in WAIT_ACK: take the ack, set overrun, no recapture.
- The edge-detect flops are the only bus-signal registers; no synchronizers, because clk is the CPU clock.

## Structure
- Shared package or include: state encodings (2-bit: IDLE=0, NMI=1, WAIT_ACK=2, RELEASE=3), the default NMI_CYCLES, and the trap-acknowledge port offset within mapper I/O space (0x38).
- Sub-module: edge_detect (one flop, rise/fall outputs), instantiated for iorq_n, m1_n and ack_strobe.
- Pulse counter: 4 bits.

## Test plan
- Reset: assert reset_n=0 with iorq_n low -> all outputs at reset values, nmi_n=1 throughout.
- OUT (0x41),0xA5 with trap_en=1, trap_hit=1 -> trap_port=0x41, trap_data=0xA5, trap_dir=1, nmi_n low exactly 4 cycles, trap_state=1.
- IN from 0x40 trapped, then ack_strobe pulse, then opcode fetch -> trap_data=0x00, trap_dir=0; trap_state low 1 cycle after the ack edge; state IDLE after the m1_n fall.
- Second trapped OUT (0x42) during WAIT_ACK -> latches still hold 0x41, overrun=1. The first ack clears nothing. A second ack edge with overrun=1 clears it.
- trap_en=0, or trap_hit=0, or an interrupt-acknowledge cycle -> no state change, nmi_n stays 1.
- reset_n pulsed low during NMI -> nmi_n returns high asynchronously, state IDLE, latches 0x00.
